rs_fp: RTL and testbench
========================

# rs_fp

Two-entry floating-point reservation station that buffers dispatched FP instructions until both source operands are available, then presents them to the FP execution unit. Captures operand values from two result broadcast buses and tracks relative age with a selector bit that points at the newer entry. Frees an entry when the execution unit pulses the matching issue line. Sits between dispatch/rename and the FP execution stage, which selects among the two entries it presents.

## Interface
Parameters:
- ENTRY_W, 114, entry width in bits
- TAG_W, 4, ROB tag width

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- dispatch_valid  in  1  new instruction offered this cycle
- dispatch_entry  in  114  entry to store (layout below)
- dispatch_rob_num  in  4  ROB entry number of the dispatched instruction
- dispatch_ready  out  1  at least one slot free; dispatch accepted only when high
- cdb0_valid, cdb1_valid  in  1 each  broadcast valid
- cdb0_tag, cdb1_tag  in  4 each  producer ROB tag
- cdb0_data, cdb1_data  in  32 each  produced value
- fp_0_issue, fp_1_issue  in  1 each  execution unit consumed slot 0 / slot 1
- rs_fp_0, rs_fp_1  out  114 each  slot contents
- rs_fp_0_entry_num, rs_fp_1_entry_num  out  4 each  slot ROB numbers
- selector  out  1  index of the newer occupied slot

Entry layout:
- [4:0] rd
- [36:5] src1 data
- [37] src1 ready
- [41:38] src1 tag
- [73:42] src2 data
- [74] src2 ready
- [78:75] src2 tag
- [79] regWrite
- [84:80] aluop
- [113:85] reserved; stored and output unchanged

## Operation
- Per-slot state: valid bit, 114-bit entry, 4-bit ROB number.
- Unoccupied slots output all zeros: entry, entry_num, and ready bits. The execution unit never sees a stale ready entry.
- dispatch_ready = !(valid0 & valid1), computed from registered state only. A slot freed by an issue in the same cycle is not reusable until the next cycle.
- Dispatch (dispatch_valid & dispatch_ready):
  - Writes slot 0 if free, otherwise slot 1.
  - Sets that slot valid.
  - Sets selector to the written slot index.
  - dispatch_valid while not ready is ignored; no state change.
- Dispatch-cycle bypass: a source with ready=0 whose tag matches a valid broadcast in the same cycle is stored with that data and ready=1.
- Wakeup, per occupied slot and per source with ready=0:
  - If cdbX_valid and cdbX_tag equals the source tag, latch cdbX_data into the source data field and set ready.
  - If both buses match, cdb0 wins.
  - Sources already ready are never overwritten.
- Issue:
  - fp_N_issue clears valid of slot N and zeroes its stored entry.
  - Issue on an unoccupied slot is ignored.
  - Both issue lines high clears both slots.
- Issue and wakeup on the same slot in the same cycle: issue wins.
- Issue of slot N and dispatch in the same cycle:
  - The dispatch targets only a slot free at the start of the cycle.
  - Both actions take effect at the same edge.
- Selector:
  - Changes only on an accepted dispatch or on reset.
  - When one slot drains, selector holds its value.
  - When both slots are empty, selector is don't-care but still registered.

## Timing
- All outputs are registered except dispatch_ready, which is combinational from registered valid bits.
- Dispatch at edge N: entry appears on rs_fp_N at N+1.
- Broadcast at edge N: ready bit and data visible from N+1.
- Issue pulse sampled at edge N: slot reads zero from N+1. dispatch_ready rises at N+1 if the station was full.
- Minimum slot turnaround is 1 cycle: issue at N, re-dispatch at N+1.
- Reset values:
  - rs_fp_0, rs_fp_1 = 0
  - entry nums = 0
  - selector = 0
  - dispatch_ready = 1
- Reset mid-operation discards all entries at the next edge. A concurrent dispatch or broadcast is ignored.

## Test plan
- Empty station, dispatch A (rob 3, both sources ready) -> next cycle rs_fp_0 = A with [37]=[74]=1, entry_num0 = 3, selector = 0, dispatch_ready = 1.
- Dispatch B (src1 tag 5, not ready), then cdb0 valid with tag 5 and data 0x3F800000 -> one cycle later B src1 data = 0x3F800000 and [37] = 1.
- Fill both slots -> dispatch_ready = 0. Further dispatch_valid is ignored and contents are unchanged. Pulse fp_0_issue -> slot 0 is zero next cycle and dispatch_ready = 1. Dispatch C -> C lands in slot 0 with selector = 0.
- Dispatch with src2 tag 7 while cdb1 broadcasts tag 7 / 0x40000000 in the same cycle -> entry stored with src2 = 0x40000000, [74] = 1.
- cdb0 and cdb1 both match tag 2 with different data -> cdb0 data is latched. Issue and matching wakeup on the same slot in the same cycle -> slot is empty next cycle.
- Assert reset with both slots full -> all outputs zero, selector = 0, dispatch_ready = 1 on the following cycle.

Source files
------------

// File: rtl/rs_fp.sv
// Two-entry FP reservation station: holds dispatched instructions, captures
// operands from two result broadcast buses, and frees slots on issue pulses.
module rs_fp #(
    parameter int ENTRY_W = 114,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dispatch_valid,
    input  logic [ENTRY_W-1:0] dispatch_entry,
    input  logic [TAG_W-1:0]   dispatch_rob_num,
    output logic               dispatch_ready,
    input  logic               cdb0_valid,
    input  logic [TAG_W-1:0]   cdb0_tag,
    input  logic [31:0]        cdb0_data,
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb1_tag,
    input  logic [31:0]        cdb1_data,
    input  logic               fp_0_issue,
    input  logic               fp_1_issue,
    output logic [ENTRY_W-1:0] rs_fp_0,
    output logic [ENTRY_W-1:0] rs_fp_1,
    output logic [TAG_W-1:0]   rs_fp_0_entry_num,
    output logic [TAG_W-1:0]   rs_fp_1_entry_num,
    output logic               selector
);

    logic [1:0]         valid;
    logic [ENTRY_W-1:0] entry [2];
    logic [TAG_W-1:0]   num   [2];
    logic [1:0]         issue;
    logic               do_disp;
    logic               tgt;

    assign issue          = {fp_1_issue, fp_0_issue};
    assign dispatch_ready = !(valid[0] && valid[1]);
    assign do_disp        = dispatch_valid && dispatch_ready;
    assign tgt            = valid[0];

    assign rs_fp_0           = entry[0];
    assign rs_fp_1           = entry[1];
    assign rs_fp_0_entry_num = num[0];
    assign rs_fp_1_entry_num = num[1];

    // Fill any not-ready source whose tag matches a live broadcast; cdb0 has priority.
    function automatic logic [ENTRY_W-1:0] wake(input logic [ENTRY_W-1:0] e);
        logic [ENTRY_W-1:0] w;
        w = e;
        if (!e[37]) begin
            if (cdb0_valid && cdb0_tag == e[41:38]) begin
                w[36:5] = cdb0_data;
                w[37]   = 1'b1;
            end else if (cdb1_valid && cdb1_tag == e[41:38]) begin
                w[36:5] = cdb1_data;
                w[37]   = 1'b1;
            end
        end
        if (!e[74]) begin
            if (cdb0_valid && cdb0_tag == e[78:75]) begin
                w[73:42] = cdb0_data;
                w[74]    = 1'b1;
            end else if (cdb1_valid && cdb1_tag == e[78:75]) begin
                w[73:42] = cdb1_data;
                w[74]    = 1'b1;
            end
        end
        return w;
    endfunction

    // Dispatch only targets a slot free at cycle start, so it outranks the
    // (then ignored) issue on that slot; issue outranks wakeup.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= '0;
            selector <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                entry[i] <= '0;
                num[i]   <= '0;
            end
        end else begin
            if (do_disp) selector <= tgt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (do_disp && tgt == i[0]) begin
                    valid[i] <= 1'b1;
                    entry[i] <= wake(dispatch_entry);
                    num[i]   <= dispatch_rob_num;
                end else if (issue[i] && valid[i]) begin
                    valid[i] <= 1'b0;
                    entry[i] <= '0;
                    num[i]   <= '0;
                end else if (valid[i]) begin
                    entry[i] <= wake(entry[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_fp.sv
// Scoreboard bench for rs_fp: directed stimulus pushes hand-computed snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rs_fp;

    logic         clk;
    logic         reset;
    logic         dispatch_valid;
    logic [113:0] dispatch_entry;
    logic [3:0]   dispatch_rob_num;
    logic         dispatch_ready;
    logic         cdb0_valid, cdb1_valid;
    logic [3:0]   cdb0_tag, cdb1_tag;
    logic [31:0]  cdb0_data, cdb1_data;
    logic         fp_0_issue, fp_1_issue;
    logic [113:0] rs_fp_0, rs_fp_1;
    logic [3:0]   rs_fp_0_entry_num, rs_fp_1_entry_num;
    logic         selector;

    rs_fp #(.ENTRY_W(114), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_entry(dispatch_entry),
        .dispatch_rob_num(dispatch_rob_num), .dispatch_ready(dispatch_ready),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .fp_0_issue(fp_0_issue), .fp_1_issue(fp_1_issue),
        .rs_fp_0(rs_fp_0), .rs_fp_1(rs_fp_1),
        .rs_fp_0_entry_num(rs_fp_0_entry_num), .rs_fp_1_entry_num(rs_fp_1_entry_num),
        .selector(selector)
    );

    typedef struct {
        int           cyc;
        string        name;
        logic [113:0] e0, e1;
        logic [3:0]   n0, n1;
        logic         sel, rdy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [113:0] mk(input logic [4:0] rd, input logic [31:0] d1,
                                        input logic r1, input logic [3:0] t1,
                                        input logic [31:0] d2, input logic r2,
                                        input logic [3:0] t2, input logic rw,
                                        input logic [4:0] op, input logic [28:0] rsv);
        return {rsv, op, rw, t2, r2, d2, t1, r1, d1, rd};
    endfunction

    task automatic cmp(input string nm, input logic [113:0] act, input logic [113:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t x;
            x = q.pop_front();
            if (x.cyc != cyc) begin
                errors++;
                $display("FAIL %s missed: actual cycle %0d required cycle %0d", x.name, cyc, x.cyc);
            end
            cmp({x.name, ".rs_fp_0"}, rs_fp_0, x.e0);
            cmp({x.name, ".rs_fp_1"}, rs_fp_1, x.e1);
            cmp({x.name, ".num0"}, 114'(rs_fp_0_entry_num), 114'(x.n0));
            cmp({x.name, ".num1"}, 114'(rs_fp_1_entry_num), 114'(x.n1));
            cmp({x.name, ".selector"}, 114'(selector), 114'(x.sel));
            cmp({x.name, ".ready"}, 114'(dispatch_ready), 114'(x.rdy));
        end
    end

    task automatic idle();
        reset = 1'b0; dispatch_valid = 1'b0; dispatch_entry = '0; dispatch_rob_num = '0;
        cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
        cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
        fp_0_issue = 1'b0; fp_1_issue = 1'b0;
    endtask

    task automatic tick(input string nm, input logic [113:0] e0, input logic [3:0] n0,
                        input logic [113:0] e1, input logic [3:0] n1,
                        input logic sel, input logic rdy);
        exp_t x;
        x.cyc = cyc + 1; x.name = nm;
        x.e0 = e0; x.n0 = n0; x.e1 = e1; x.n1 = n1; x.sel = sel; x.rdy = rdy;
        q.push_back(x);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic disp(input logic [113:0] e, input logic [3:0] rob);
        dispatch_valid = 1'b1; dispatch_entry = e; dispatch_rob_num = rob;
    endtask

    logic [113:0] a, b, b_w, c, c_w, d, e, f, f_w, g, h;

    initial begin
        a   = mk(5'd1, 32'h11111111, 1'b1, 4'd0, 32'h22222222, 1'b1, 4'd0, 1'b1, 5'd3, 29'h0ABCDEF);
        b   = mk(5'd2, 32'h0, 1'b0, 4'd5, 32'h33333333, 1'b1, 4'd0, 1'b1, 5'd4, 29'h0);
        b_w = mk(5'd2, 32'h3F800000, 1'b1, 4'd5, 32'h33333333, 1'b1, 4'd0, 1'b1, 5'd4, 29'h0);
        c   = mk(5'd3, 32'h44444444, 1'b1, 4'd0, 32'h0, 1'b0, 4'd7, 1'b0, 5'd5, 29'h0);
        c_w = mk(5'd3, 32'h44444444, 1'b1, 4'd0, 32'h40000000, 1'b1, 4'd7, 1'b0, 5'd5, 29'h0);
        d   = mk(5'd9, 32'hDEADBEEF, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 1'b1, 5'd9, 29'h1);
        e   = mk(5'd4, 32'h0, 1'b0, 4'd2, 32'h0, 1'b0, 4'd2, 1'b1, 5'd6, 29'h0);
        f   = mk(5'd5, 32'h0, 1'b0, 4'd2, 32'h55555555, 1'b1, 4'd0, 1'b0, 5'd7, 29'h1FFFFFFF);
        f_w = mk(5'd5, 32'hAAAA0000, 1'b1, 4'd2, 32'h55555555, 1'b1, 4'd0, 1'b0, 5'd7, 29'h1FFFFFFF);
        g   = mk(5'd6, 32'h12345678, 1'b1, 4'd0, 32'h9ABCDEF0, 1'b1, 4'd0, 1'b1, 5'd8, 29'h0);
        h   = mk(5'd7, 32'h0, 1'b0, 4'd9, 32'h0, 1'b0, 4'd10, 1'b0, 5'd1, 29'h0);

        idle();
        reset = 1'b1;
        tick("reset", '0, 4'd0, '0, 4'd0, 1'b0, 1'b1);

        disp(a, 4'd3);
        tick("disp_a", a, 4'd3, '0, 4'd0, 1'b0, 1'b1);

        disp(b, 4'd5);
        tick("disp_b", a, 4'd3, b, 4'd5, 1'b1, 1'b0);

        // full station: dispatch ignored while cdb0 wakes B's src1
        disp(d, 4'd9);
        cdb0_valid = 1'b1; cdb0_tag = 4'd5; cdb0_data = 32'h3F800000;
        tick("wake_b", a, 4'd3, b_w, 4'd5, 1'b1, 1'b0);

        fp_0_issue = 1'b1;
        tick("issue0", '0, 4'd0, b_w, 4'd5, 1'b1, 1'b1);

        disp(c, 4'd9);
        cdb1_valid = 1'b1; cdb1_tag = 4'd7; cdb1_data = 32'h40000000;
        tick("bypass_c", c_w, 4'd9, b_w, 4'd5, 1'b0, 1'b0);

        fp_0_issue = 1'b1; fp_1_issue = 1'b1;
        tick("issue_both", '0, 4'd0, '0, 4'd0, 1'b0, 1'b1);

        disp(e, 4'd2);
        tick("disp_e", e, 4'd2, '0, 4'd0, 1'b0, 1'b1);

        disp(f, 4'd4);
        tick("disp_f", e, 4'd2, f, 4'd4, 1'b1, 1'b0);

        // slot 0 issued while woken (issue wins); slot 1 takes cdb0 over cdb1
        fp_0_issue = 1'b1;
        cdb0_valid = 1'b1; cdb0_tag = 4'd2; cdb0_data = 32'hAAAA0000;
        cdb1_valid = 1'b1; cdb1_tag = 4'd2; cdb1_data = 32'hBBBB0000;
        tick("prio_issue", '0, 4'd0, f_w, 4'd4, 1'b1, 1'b1);

        // dispatch into free slot 0 ignores issue on it; slot 1 issue frees it
        disp(g, 4'd6);
        fp_0_issue = 1'b1; fp_1_issue = 1'b1;
        tick("disp_issue", g, 4'd6, '0, 4'd0, 1'b0, 1'b1);

        disp(h, 4'd7);
        tick("disp_h", g, 4'd6, h, 4'd7, 1'b1, 1'b0);

        reset = 1'b1;
        disp(d, 4'd1);
        cdb0_valid = 1'b1; cdb0_tag = 4'd9; cdb0_data = 32'h77777777;
        tick("reset_full", '0, 4'd0, '0, 4'd0, 1'b0, 1'b1);

        tick("post_reset", '0, 4'd0, '0, 4'd0, 1'b0, 1'b1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", q.size());
        end
        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
